// File: rtl/mem_if_arbiter.sv
// Round-robin arbiter sharing the memory-configuration port between two requesters.
// Define MEM_ACK_TIMEOUT_EN to abort transactions whose mem_ack never arrives.
module mem_if_arbiter #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wr_data,
    input  logic              req0_wr_rd_s,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rd_data,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wr_data,
    input  logic              req1_wr_rd_s,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rd_data,
    output logic              req1_err,
    output logic              mem_sel_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_rd_s,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_ack
);

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC must lie in 2..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [1:0]        ready_q, ready_d;
    logic [1:0]        done_q, done_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              gnt_c;
    logic              fin_c;
    logic [DATA_W-1:0] fin_data_c;
`ifdef MEM_ACK_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        err_q, err_d;
    logic              fin_err_c;
`endif

    // Next-state, grant selection and registered-output values
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        ready_d      = '0;
        done_d       = '0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        gnt_c        = 1'b0;
        fin_c        = 1'b0;
        fin_data_c   = '0;
`ifdef MEM_ACK_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
        fin_err_c    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the requester that did not win last time goes next
                    if (req0_valid && req1_valid) begin
                        gnt_c = ~last_grant_q;
                    end else begin
                        gnt_c = req1_valid;
                    end
                    owner_d        = gnt_c;
                    last_grant_d   = gnt_c;
                    state_d        = BUSY;
                    sel_d          = 1'b1;
                    ready_d[gnt_c] = 1'b1;
                    addr_d         = gnt_c ? req1_addr    : req0_addr;
                    wdata_d        = gnt_c ? req1_wr_data : req0_wr_data;
                    wr_d           = gnt_c ? req1_wr_rd_s : req0_wr_rd_s;
`ifdef MEM_ACK_TIMEOUT_EN
                    cnt_d          = '0;
`endif
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    fin_c      = 1'b1;
                    fin_data_c = wr_q ? '0 : mem_rd_data;
`ifdef MEM_ACK_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    fin_c      = 1'b1;
                    fin_err_c  = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin_c) begin
            state_d          = IDLE;
            sel_d            = 1'b0;
            done_d[owner_q]  = 1'b1;
            if (owner_q) begin
                rdata1_d = fin_data_c;
            end else begin
                rdata0_d = fin_data_c;
            end
`ifdef MEM_ACK_TIMEOUT_EN
            err_d[owner_q]   = fin_err_c;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            sel_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            ready_q      <= '0;
            done_q       <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
`ifdef MEM_ACK_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifdef MEM_ACK_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign req0_ready   = ready_q[0];
    assign req1_ready   = ready_q[1];
    assign req0_done    = done_q[0];
    assign req1_done    = done_q[1];
    assign req0_rd_data = rdata0_q;
    assign req1_rd_data = rdata1_q;
`ifdef MEM_ACK_TIMEOUT_EN
    assign req0_err     = err_q[0];
    assign req1_err     = err_q[1];
`else
    assign req0_err     = 1'b0;
    assign req1_err     = 1'b0;
`endif
    assign mem_sel_en   = sel_q;
    assign mem_addr     = addr_q;
    assign mem_wr_data  = wdata_q;
    assign mem_wr_rd_s  = wr_q;

endmodule

// File: tb/tb_mem_if_arbiter.sv
// Scoreboard bench for mem_if_arbiter: directed requests, a programmable memory responder,
// and a negedge monitor that checks memory-side transactions and done pulses against queues.
module tb_mem_if_arbiter;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_wr_data, req1_wr_data;
    logic              req0_wr_rd_s, req1_wr_rd_s;
    logic              req0_ready, req1_ready;
    logic              req0_done, req1_done;
    logic [DATA_W-1:0] req0_rd_data, req1_rd_data;
    logic              req0_err, req1_err;
    logic              mem_sel_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_rd_s;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_ack;

    mem_if_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wr_data(req0_wr_data),
        .req0_wr_rd_s(req0_wr_rd_s), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_rd_data(req0_rd_data), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wr_data(req1_wr_data),
        .req1_wr_rd_s(req1_wr_rd_s), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_rd_data(req1_rd_data), .req1_err(req1_err),
        .mem_sel_en(mem_sel_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_rd_s(mem_wr_rd_s), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] addr;
        logic [7:0] data;
        logic       wr;
        int         len;
        int         gap;
    } mem_exp_t;

    typedef struct {
        int         id;
        logic [7:0] rd;
        logic       err;
    } done_exp_t;

    mem_exp_t  exp_mem[$];
    done_exp_t exp_done[$];
    int        n_cmp  = 0;
    int        n_fail = 0;
    int        ack_wait  = 0;
    logic [7:0] rd_val   = 8'h00;
    logic      ack_force = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic mem_exp_t mk_mem(int id, logic [7:0] a, logic [7:0] d, logic w, int len, int gap);
        mem_exp_t m;
        m.id = id; m.addr = a; m.data = d; m.wr = w; m.len = len; m.gap = gap;
        return m;
    endfunction

    function automatic done_exp_t mk_done(int id, logic [7:0] rd, logic err);
        done_exp_t e;
        e.id = id; e.rd = rd; e.err = err;
        return e;
    endfunction

    // Memory responder: acks ack_wait cycles after mem_sel_en rises
    initial begin
        int age;
        age = 0;
        mem_ack = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            mem_ack = ack_force;
            mem_rd_data = rd_val;
            if (mem_sel_en) begin
                if (age == ack_wait) mem_ack = 1'b1;
                age++;
            end else begin
                age = 0;
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents a transaction or a done pulse
    logic      prev_sel = 1'b0;
    int        hi_cnt   = 0;
    int        lo_cnt   = 0;
    mem_exp_t  cur;
    done_exp_t de;
    initial begin
        cur = mk_mem(0, 8'h00, 8'h00, 1'b0, 0, -1);
        forever begin
            @(negedge clk);
            if ((req0_ready || req1_ready) && !(mem_sel_en && !prev_sel))
                chk("stray_ready", 32'({req1_ready, req0_ready}), 32'd0);
            if (mem_sel_en && !prev_sel) begin
                if (exp_mem.size() == 0) begin
                    chk("unexpected_sel", 32'(mem_sel_en), 32'd0);
                end else begin
                    cur = exp_mem.pop_front();
                    chk("sel_addr",  32'(mem_addr),    32'(cur.addr));
                    chk("sel_wdata", 32'(mem_wr_data), 32'(cur.data));
                    chk("sel_wr",    32'(mem_wr_rd_s), 32'(cur.wr));
                    chk("grant_ready", 32'({req1_ready, req0_ready}), (cur.id == 0) ? 32'd1 : 32'd2);
                    if (cur.gap >= 0) chk("idle_gap", 32'(lo_cnt), 32'(cur.gap));
                end
                hi_cnt = 1;
            end else if (mem_sel_en) begin
                hi_cnt++;
                chk("sel_stable", 32'({mem_addr, mem_wr_data, mem_wr_rd_s}),
                    32'({cur.addr, cur.data, cur.wr}));
            end else if (prev_sel) begin
                chk("sel_len", 32'(hi_cnt), 32'(cur.len));
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
            if (req0_done || req1_done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'({req1_done, req0_done}), 32'd0);
                end else begin
                    de = exp_done.pop_front();
                    chk("done_id", 32'({req1_done, req0_done}), (de.id == 0) ? 32'd1 : 32'd2);
                    chk("done_rd_data", 32'((de.id == 0) ? req0_rd_data : req1_rd_data), 32'(de.rd));
                    chk("done_err", 32'((de.id == 0) ? req0_err : req1_err), 32'(de.err));
                end
            end
            prev_sel = mem_sel_en;
        end
    end

    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] d, input logic w);
        int budget;
        logic rdy;
        budget = 0;
        if (id == 0) begin
            req0_valid = 1'b1; req0_addr = a; req0_wr_data = d; req0_wr_rd_s = w;
        end else begin
            req1_valid = 1'b1; req1_addr = a; req1_wr_data = d; req1_wr_rd_s = w;
        end
        do begin
            @(posedge clk); #1;
            budget++;
            rdy = (id == 0) ? req0_ready : req1_ready;
        end while (!rdy && budget < 100);
        chk("ready_wait", 32'(rdy), 32'd1);
    endtask

    task automatic release_req(input int id);
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_mem.size() != 0 || exp_done.size() != 0) && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_queues", 32'(exp_mem.size() + exp_done.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_wr_data = '0; req0_wr_rd_s = 1'b0;
        req1_valid = 1'b0; req1_addr = '0; req1_wr_data = '0; req1_wr_rd_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({req0_ready, req1_ready, req0_done, req1_done,
                             req0_err, req1_err, mem_sel_en, mem_wr_rd_s}), 32'd0);
        chk("rst_rd_data", 32'({req0_rd_data, req1_rd_data}), 32'd0);
        chk("rst_mem_bus", 32'({mem_addr, mem_wr_data}), 32'd0);
        rst = 1'b0;

        // Idle with a stray ack that must be ignored
        for (int i = 0; i < 10; i++) begin
            ack_force = (i == 4);
            @(posedge clk); #1;
            chk("idle_outputs", 32'({req0_ready, req1_ready, req0_done, req1_done,
                                     req0_err, req1_err, mem_sel_en}), 32'd0);
        end
        ack_force = 1'b0;

        // req0 write, ack two cycles after sel
        ack_wait = 2; rd_val = 8'hEE;
        exp_mem.push_back(mk_mem(0, 8'h05, 8'hA3, 1'b1, 3, -1));
        exp_done.push_back(mk_done(0, 8'h00, 1'b0));
        issue(0, 8'h05, 8'hA3, 1'b1);
        release_req(0);
        drain();

        // req1 read, ack in the first busy cycle
        ack_wait = 0; rd_val = 8'h5C;
        exp_mem.push_back(mk_mem(1, 8'h10, 8'h77, 1'b0, 1, -1));
        exp_done.push_back(mk_done(1, 8'h5C, 1'b0));
        issue(1, 8'h10, 8'h77, 1'b0);
        release_req(1);
        drain();
        chk("req0_rd_untouched", 32'(req0_rd_data), 32'h00);
        chk("req0_err_untouched", 32'(req0_err), 32'd0);
        chk("req1_rd_hold", 32'(req1_rd_data), 32'h5C);

        // Both requesters continuously valid: strict alternation
        ack_wait = 1; rd_val = 8'h9D;
        exp_mem.push_back(mk_mem(0, 8'h20, 8'h11, 1'b1, 2, -1));
        exp_mem.push_back(mk_mem(1, 8'h30, 8'h00, 1'b0, 2, 1));
        exp_mem.push_back(mk_mem(0, 8'h21, 8'h00, 1'b0, 2, 1));
        exp_mem.push_back(mk_mem(1, 8'h31, 8'h44, 1'b1, 2, 1));
        exp_done.push_back(mk_done(0, 8'h00, 1'b0));
        exp_done.push_back(mk_done(1, 8'h9D, 1'b0));
        exp_done.push_back(mk_done(0, 8'h9D, 1'b0));
        exp_done.push_back(mk_done(1, 8'h00, 1'b0));
        fork
            begin
                issue(0, 8'h20, 8'h11, 1'b1);
                issue(0, 8'h21, 8'h00, 1'b0);
                release_req(0);
            end
            begin
                issue(1, 8'h30, 8'h00, 1'b0);
                issue(1, 8'h31, 8'h44, 1'b1);
                release_req(1);
            end
        join
        drain();
        chk("req0_rd_hold", 32'(req0_rd_data), 32'h9D);
        chk("req1_rd_hold_wr", 32'(req1_rd_data), 32'h00);

        // Reset while a req0 read is in flight; no done may follow
        ack_wait = 1000;
        exp_mem.push_back(mk_mem(0, 8'h40, 8'h00, 1'b0, 3, -1));
        issue(0, 8'h40, 8'h00, 1'b0);
        release_req(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_sel", 32'(mem_sel_en), 32'd0);
        chk("rst_mid_pulses", 32'({req0_ready, req1_ready, req0_done, req1_done}), 32'd0);

        // Simultaneous request after reset goes to req0
        ack_wait = 0; rd_val = 8'h3C;
        exp_mem.push_back(mk_mem(0, 8'h41, 8'h5A, 1'b1, 1, -1));
        exp_mem.push_back(mk_mem(1, 8'h42, 8'h00, 1'b0, 1, 1));
        exp_done.push_back(mk_done(0, 8'h00, 1'b0));
        exp_done.push_back(mk_done(1, 8'h3C, 1'b0));
        fork
            begin
                issue(0, 8'h41, 8'h5A, 1'b1);
                release_req(0);
            end
            begin
                issue(1, 8'h42, 8'h00, 1'b0);
                release_req(1);
            end
        join
        drain();

`ifdef MEM_ACK_TIMEOUT_EN
        // Ack never arrives: abort after TIMEOUT_CYC busy cycles
        ack_wait = 1000; rd_val = 8'h77;
        exp_mem.push_back(mk_mem(1, 8'h55, 8'h00, 1'b0, TIMEOUT_CYC, -1));
        exp_done.push_back(mk_done(1, 8'h00, 1'b1));
        issue(1, 8'h55, 8'h00, 1'b0);
        release_req(1);
        drain();

        // Ack on the same edge as the limit completes normally
        ack_wait = TIMEOUT_CYC - 1;
        exp_mem.push_back(mk_mem(0, 8'h56, 8'h00, 1'b0, TIMEOUT_CYC, -1));
        exp_done.push_back(mk_done(0, 8'h77, 1'b0));
        issue(0, 8'h56, 8'h00, 1'b0);
        release_req(0);
        drain();
`else
        // Without the timeout a slow ack is simply waited for
        ack_wait = 40; rd_val = 8'h77;
        exp_mem.push_back(mk_mem(1, 8'h55, 8'h00, 1'b0, 41, -1));
        exp_done.push_back(mk_done(1, 8'h77, 1'b0));
        issue(1, 8'h55, 8'h00, 1'b0);
        release_req(1);
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
